// File: rtl/sensor_packet_mux.sv
// sensor_packet_mux: round-robin arbiter and byte-stream packet framer for
// sensor channels. Packet: HEADER, channel ID, sequence, [timestamp hi/lo],
// payload MSB first, mod-256 checksum of all bytes after HEADER.
// Optional feature macro: SENSOR_PKT_TIMESTAMP_EN (adds 16-bit timestamp).
module sensor_packet_mux #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned DATA_W = 24,
    parameter logic [7:0]  HEADER = 8'hA5
) (
    input  logic                     i_CLK,
    input  logic                     i_RST,
    input  logic [NUM_CH*DATA_W-1:0] i_CH_DATA,
    input  logic [NUM_CH-1:0]        i_CH_VALID,
    input  logic [NUM_CH-1:0]        i_CH_ENABLE,
    output logic [NUM_CH-1:0]        o_CH_ACK,
    output logic [7:0]               o_TX_BYTE,
    output logic                     o_TX_VALID,
    input  logic                     i_TX_READY,
    output logic                     o_BUSY,
    output logic [7:0]               o_SEQ
);

    localparam int unsigned DATA_BYTES = DATA_W / 8;
    localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned CNT_W      = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;

`ifdef SENSOR_PKT_TIMESTAMP_EN
    typedef enum logic [2:0] {IDLE, HDR, ID, SEQ, TS_HI, TS_LO, DATA, CSUM} state_t;
`else
    typedef enum logic [2:0] {IDLE, HDR, ID, SEQ, DATA, CSUM} state_t;
`endif

    state_t              state_q, state_d;
    logic [7:0]          tx_byte_q, tx_byte_d;
    logic                tx_valid_q, tx_valid_d;
    logic [NUM_CH-1:0]   ack_q, ack_d;
    logic                busy_q, busy_d;
    logic [7:0]          seq_q, seq_d;
    logic [7:0]          csum_q, csum_d;
    logic [7:0]          id_q, id_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CH_W-1:0]     rr_q, rr_d;
`ifdef SENSOR_PKT_TIMESTAMP_EN
    logic [15:0]         ts_cnt_q, ts_cnt_d;
    logic [15:0]         ts_q, ts_d;
`endif

    logic [NUM_CH-1:0]   req;
    logic                grant_found;
    logic [CH_W-1:0]     grant_idx;
    logic                xfer;
    logic [DATA_W-1:0]   data_shift;

    assign req        = i_CH_VALID & i_CH_ENABLE;
    assign xfer       = tx_valid_q & i_TX_READY;
    assign data_shift = data_q << 8;

    // Round-robin pick: first requester at or above rr_q, then wrap to below it
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int unsigned j = 0; j < NUM_CH; j++) begin
            if (!grant_found && (j >= 32'(rr_q)) && req[j]) begin
                grant_found = 1'b1;
                grant_idx   = CH_W'(j);
            end
        end
        for (int unsigned j = 0; j < NUM_CH; j++) begin
            if (!grant_found && (j < 32'(rr_q)) && req[j]) begin
                grant_found = 1'b1;
                grant_idx   = CH_W'(j);
            end
        end
    end

    // Next-state and next-output logic; outputs are registered from *_d
    always_comb begin
        state_d    = state_q;
        tx_byte_d  = tx_byte_q;
        tx_valid_d = tx_valid_q;
        ack_d      = '0;
        seq_d      = seq_q;
        csum_d     = csum_q;
        id_d       = id_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        rr_d       = rr_q;
`ifdef SENSOR_PKT_TIMESTAMP_EN
        ts_cnt_d   = ts_cnt_q + 16'd1;
        ts_d       = ts_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    state_d          = HDR;
                    tx_byte_d        = HEADER;
                    tx_valid_d       = 1'b1;
                    ack_d[grant_idx] = 1'b1;
                    id_d             = 8'(grant_idx);
                    data_d           = i_CH_DATA[32'(grant_idx)*DATA_W +: DATA_W];
                    csum_d           = 8'h00;
                    rr_d             = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
`ifdef SENSOR_PKT_TIMESTAMP_EN
                    ts_d             = ts_cnt_q;
`endif
                end
            end
            HDR: begin
                if (xfer) begin
                    state_d   = ID;
                    tx_byte_d = id_q;
                end
            end
            ID: begin
                if (xfer) begin
                    state_d   = SEQ;
                    tx_byte_d = seq_q;
                    csum_d    = csum_q + tx_byte_q;
                end
            end
            SEQ: begin
                if (xfer) begin
                    csum_d    = csum_q + tx_byte_q;
`ifdef SENSOR_PKT_TIMESTAMP_EN
                    state_d   = TS_HI;
                    tx_byte_d = ts_q[15:8];
`else
                    state_d   = DATA;
                    tx_byte_d = data_q[DATA_W-1 -: 8];
                    cnt_d     = '0;
`endif
                end
            end
`ifdef SENSOR_PKT_TIMESTAMP_EN
            TS_HI: begin
                if (xfer) begin
                    state_d   = TS_LO;
                    tx_byte_d = ts_q[7:0];
                    csum_d    = csum_q + tx_byte_q;
                end
            end
            TS_LO: begin
                if (xfer) begin
                    state_d   = DATA;
                    tx_byte_d = data_q[DATA_W-1 -: 8];
                    cnt_d     = '0;
                    csum_d    = csum_q + tx_byte_q;
                end
            end
`endif
            DATA: begin
                if (xfer) begin
                    csum_d = csum_q + tx_byte_q;
                    if (cnt_q == CNT_W'(DATA_BYTES - 1)) begin
                        state_d   = CSUM;
                        tx_byte_d = csum_q + tx_byte_q;
                    end else begin
                        cnt_d     = cnt_q + 1'b1;
                        data_d    = data_shift;
                        tx_byte_d = data_shift[DATA_W-1 -: 8];
                    end
                end
            end
            CSUM: begin
                if (xfer) begin
                    state_d    = IDLE;
                    tx_valid_d = 1'b0;
                    seq_d      = seq_q + 8'd1;
                end
            end
            default: begin
                state_d    = IDLE;
                tx_valid_d = 1'b0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers, asynchronously cleared
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_q    <= IDLE;
            tx_byte_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            ack_q      <= '0;
            busy_q     <= 1'b0;
            seq_q      <= 8'h00;
            csum_q     <= 8'h00;
            id_q       <= 8'h00;
            data_q     <= '0;
            cnt_q      <= '0;
            rr_q       <= '0;
`ifdef SENSOR_PKT_TIMESTAMP_EN
            ts_cnt_q   <= 16'h0000;
            ts_q       <= 16'h0000;
`endif
        end else begin
            state_q    <= state_d;
            tx_byte_q  <= tx_byte_d;
            tx_valid_q <= tx_valid_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            seq_q      <= seq_d;
            csum_q     <= csum_d;
            id_q       <= id_d;
            data_q     <= data_d;
            cnt_q      <= cnt_d;
            rr_q       <= rr_d;
`ifdef SENSOR_PKT_TIMESTAMP_EN
            ts_cnt_q   <= ts_cnt_d;
            ts_q       <= ts_d;
`endif
        end
    end

    assign o_CH_ACK   = ack_q;
    assign o_TX_BYTE  = tx_byte_q;
    assign o_TX_VALID = tx_valid_q;
    assign o_BUSY     = busy_q;
    assign o_SEQ      = seq_q;

endmodule

// File: tb/tb_sensor_packet_mux.sv
// Self-checking bench for sensor_packet_mux (default build, NUM_CH=2, DATA_W=24).
// A packet-level reference model predicts grants, byte stream and sequence.
module tb_sensor_packet_mux;

    localparam int unsigned NUM_CH = 2;
    localparam int unsigned DATA_W = 24;
    localparam logic [7:0]  HEADER = 8'hA5;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [DATA_W-1:0]        dat [NUM_CH];
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic [NUM_CH-1:0]        valid, en, ack;
    logic [7:0]               tx_byte, seq;
    logic                     tx_valid, ready, busy;

    assign ch_data = {dat[1], dat[0]};

    always #5 clk = ~clk;

    sensor_packet_mux #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .HEADER(HEADER)) dut (
        .i_CLK(clk), .i_RST(rst), .i_CH_DATA(ch_data), .i_CH_VALID(valid),
        .i_CH_ENABLE(en), .o_CH_ACK(ack), .o_TX_BYTE(tx_byte), .o_TX_VALID(tx_valid),
        .i_TX_READY(ready), .o_BUSY(busy), .o_SEQ(seq)
    );

    // reference model state
    logic [7:0]        exp_q[$];
    bit                m_busy;
    logic [7:0]        m_seq;
    int                m_rr;
    logic [NUM_CH-1:0] m_ack_exp;
    bit                auto_drop;

    int checks = 0, errors = 0;
    int cyc = 0, pkts = 0;
    logic [7:0]        last_byte;
    logic [NUM_CH-1:0] seen_ack;
    int                ack_cyc[$];

    typedef struct {
        logic [NUM_CH-1:0] valid;
        logic [NUM_CH-1:0] en;
        logic [DATA_W-1:0] d0;
        logic [DATA_W-1:0] d1;
        logic [NUM_CH-1:0] exp_ack;
        logic [7:0]        exp_csum;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock of model + comparison; inputs for this cycle are already driven
    task automatic tick();
        bit                nb;
        logic [7:0]        ns, sum, b;
        logic [NUM_CH-1:0] nack, req;
        int                g;
        nb = m_busy; ns = m_seq; nack = '0; g = -1;
        chk("ack", 32'(ack), 32'(m_ack_exp));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("tx_valid", 32'(tx_valid), 32'(m_busy));
        chk("seq_out", 32'(seq), 32'(m_seq));
        if (ack != '0) begin
            seen_ack = ack;
            ack_cyc.push_back(cyc);
        end
        if (m_busy) begin
            if (exp_q.size() == 0) begin
                chk("model_queue", 32'(0), 32'(1));
            end else begin
                chk("tx_byte", 32'(tx_byte), 32'(exp_q[0]));
                if (ready) begin
                    last_byte = tx_byte;
                    void'(exp_q.pop_front());
                    if (exp_q.size() == 0) begin
                        nb = 1'b0;
                        ns = m_seq + 8'd1;
                        pkts++;
                    end
                end
            end
        end else begin
            req = valid & en;
            for (int i = 0; i < int'(NUM_CH); i++) begin
                int k;
                k = (m_rr + i) % int'(NUM_CH);
                if (g < 0 && req[k]) g = k;
            end
            if (g >= 0) begin
                exp_q.push_back(HEADER);
                exp_q.push_back(8'(g));
                exp_q.push_back(m_seq);
                sum = 8'(g) + m_seq;
                for (int i = 0; i < int'(DATA_W / 8); i++) begin
                    b = dat[g][DATA_W-1-8*i -: 8];
                    sum = sum + b;
                    exp_q.push_back(b);
                end
                exp_q.push_back(sum);
                nb = 1'b1;
                nack[g] = 1'b1;
                m_rr = (g + 1) % int'(NUM_CH);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        m_busy = nb; m_seq = ns; m_ack_exp = nack;
        if (auto_drop) valid = valid & ~nack;
    endtask

    task automatic run_until_pkts(input int target, input int budget);
        for (int n = 0; n < budget && pkts < target; n++) tick();
        if (pkts < target) chk("timeout_pkts", 32'(pkts), 32'(target));
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_busy = 1'b0; m_seq = 8'h00; m_rr = 0; m_ack_exp = '0;
    endtask

    initial begin
        vecs[0] = '{valid: 2'b01, en: 2'b11, d0: 24'h123456, d1: 24'h000000, exp_ack: 2'b01, exp_csum: 8'h9C};
        vecs[1] = '{valid: 2'b11, en: 2'b11, d0: 24'h000001, d1: 24'hABCDEF, exp_ack: 2'b10, exp_csum: 8'h69};
        vecs[2] = '{valid: 2'b11, en: 2'b11, d0: 24'h000001, d1: 24'h111111, exp_ack: 2'b01, exp_csum: 8'h03};
        vecs[3] = '{valid: 2'b11, en: 2'b01, d0: 24'hFFFFFF, d1: 24'hABCDEF, exp_ack: 2'b01, exp_csum: 8'h00};
        vecs[4] = '{valid: 2'b10, en: 2'b10, d0: 24'h000000, d1: 24'h800000, exp_ack: 2'b10, exp_csum: 8'h85};

        rst = 1'b1; valid = '0; en = 2'b11; ready = 1'b1; dat[0] = '0; dat[1] = '0;
        auto_drop = 1'b1;
        model_reset();
        #12;
        chk("rst_ack", 32'(ack), 32'(0));
        chk("rst_byte", 32'(tx_byte), 32'(0));
        chk("rst_valid", 32'(tx_valid), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_seq", 32'(seq), 32'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        tick();

        // table-driven single packets
        for (int v = 0; v < 5; v++) begin
            int p0;
            p0 = pkts;
            valid = vecs[v].valid; en = vecs[v].en;
            dat[0] = vecs[v].d0; dat[1] = vecs[v].d1;
            seen_ack = '0;
            run_until_pkts(p0 + 1, 40);
            chk($sformatf("vec%0d_ack", v), 32'(seen_ack), 32'(vecs[v].exp_ack));
            chk($sformatf("vec%0d_csum", v), 32'(last_byte), 32'(vecs[v].exp_csum));
        end

        // back-to-back packets: one IDLE cycle between them
        valid = '0;
        tick();
        ack_cyc.delete();
        valid = 2'b11; en = 2'b11; dat[0] = 24'h000001; dat[1] = 24'hABCDEF;
        run_until_pkts(pkts + 2, 40);
        if (ack_cyc.size() >= 2) chk("b2b_period", 32'(ack_cyc[1] - ack_cyc[0]), 32'(8));
        else chk("b2b_acks", 32'(ack_cyc.size()), 32'(2));

        // stall on second payload byte for 5 cycles; mid-packet input changes ignored
        valid = 2'b01; dat[0] = 24'h123456;
        for (int n = 0; n < 20 && !(m_busy && exp_q.size() == 3); n++) tick();
        chk("stall_reached", 32'(exp_q.size()), 32'(3));
        ready = 1'b0;
        dat[0] = 24'h000000; en = 2'b10;
        for (int n = 0; n < 5; n++) begin
            chk("stall_byte", 32'(tx_byte), 32'(8'h34));
            tick();
        end
        ready = 1'b1; en = 2'b11;
        run_until_pkts(pkts + 1, 20);

        // disabled channel is never granted until enabled
        valid = 2'b10; en = 2'b01; dat[1] = 24'h5A5A5A;
        for (int n = 0; n < 10; n++) tick();
        seen_ack = '0;
        en = 2'b11;
        run_until_pkts(pkts + 1, 20);
        chk("enable_ack", 32'(seen_ack), 32'(2'b10));

        // asynchronous reset mid-DATA
        valid = 2'b01; dat[0] = DATA_W'($urandom);
        for (int n = 0; n < 20 && !(m_busy && exp_q.size() == 3); n++) tick();
        rst = 1'b1;
        #1;
        chk("arst_ack", 32'(ack), 32'(0));
        chk("arst_byte", 32'(tx_byte), 32'(0));
        chk("arst_valid", 32'(tx_valid), 32'(0));
        chk("arst_busy", 32'(busy), 32'(0));
        chk("arst_seq", 32'(seq), 32'(0));
        model_reset();
        valid = '0;
        @(posedge clk); #1;
        rst = 1'b0;

        // 257 packets from ch0 with valid held: sequence wraps FF -> 00
        auto_drop = 1'b0; valid = 2'b01; en = 2'b01;
        begin
            int p0;
            p0 = pkts;
            for (int n = 0; n < 257 * 8 + 20 && pkts < p0 + 257; n++) begin
                tick();
                if (m_ack_exp != '0) dat[0] = DATA_W'($urandom);
            end
            chk("wrap_pkts", 32'(pkts - p0), 32'(257));
        end
        valid = '0; auto_drop = 1'b1;
        for (int n = 0; n < 20 && m_busy; n++) tick();
        chk("wrap_seq", 32'(seq), 32'(8'h01));

        // randomized traffic against the model
        en = 2'b11;
        for (int n = 0; n < 3000; n++) begin
            ready = ($urandom_range(3) != 0);
            for (int k = 0; k < int'(NUM_CH); k++) begin
                if (!valid[k] && $urandom_range(4) == 0) begin
                    dat[k] = DATA_W'($urandom);
                    valid[k] = 1'b1;
                end
            end
            if ($urandom_range(15) == 0) en = NUM_CH'($urandom);
            tick();
        end
        valid = '0; ready = 1'b1;
        for (int n = 0; n < 30 && m_busy; n++) tick();
        chk("drain_idle", 32'(busy), 32'(0));
        chk("drain_queue", 32'(exp_q.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
